// File: rtl/out_fifo_return_arbiter_pkg.sv
// Shared controller package for the output-FIFO return arbiter:
// default geometry and the arbiter state encoding.
package out_fifo_return_arbiter_pkg;

  localparam int NUM_BANK_DEF   = 4;
  localparam int OUT_FIFO_WIDTH = 65;
  localparam int MAX_BURST_DEF  = 4;

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } arb_state_t;

endpackage

// File: rtl/out_fifo_return_arbiter_rr_priority_pick.sv
// Wrap-around first-one search: lowest set bit of req at or after start,
// continuing past the top index back to zero.
module rr_priority_pick #(
  parameter int N  = 4,
  parameter int IW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] start,
  output logic          found,
  output logic [IW-1:0] idx
);

  always_comb begin
    int c;
    c     = 0;
    found = 1'b0;
    idx   = '0;
    for (int i = 0; i < N; i++) begin
      c = (int'(start) + i) % N;
      if (!found && req[c]) begin
        found = 1'b1;
        idx   = IW'(c);
      end
    end
  end

endmodule

// File: rtl/out_fifo_return_arbiter.sv
// Drains NUM_BANK fall-through output FIFOs onto one host beat stream,
// round-robin between banks with bursts capped at MAX_BURST beats.
module out_fifo_return_arbiter
  import out_fifo_return_arbiter_pkg::*;
#(
  parameter  int NUM_BANK  = NUM_BANK_DEF,
  parameter  int DATA_W    = OUT_FIFO_WIDTH,
  parameter  int MAX_BURST = MAX_BURST_DEF,
  localparam int ID_W      = (NUM_BANK > 1) ? $clog2(NUM_BANK) : 1,
  localparam int CNT_W     = $clog2(MAX_BURST) + 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_BANK-1:0]        fifo_empty,
  input  logic [NUM_BANK*DATA_W-1:0] fifo_data,
  output logic [NUM_BANK-1:0]        fifo_ren,
  output logic                       out_valid,
  output logic [DATA_W-1:0]          out_data,
  output logic [ID_W-1:0]            out_bank_id,
  input  logic                       out_ready
);

  arb_state_t       state, state_n;
  logic [ID_W-1:0]  grant, grant_n;
  logic [ID_W-1:0]  rr_ptr, rr_n;
  logic [CNT_W-1:0] beat_cnt, beat_n;
  logic [ID_W-1:0]  grant_inc;
  logic [ID_W-1:0]  pick_start;
  logic             pick_found;
  logic [ID_W-1:0]  pick_idx;
  logic             load_ok;
  logic             pop_en;
  logic [ID_W-1:0]  pop_idx;

  assign load_ok   = !out_valid || out_ready;
  assign grant_inc = (grant == ID_W'(NUM_BANK - 1)) ? '0 : grant + 1'b1;
  // Starting one past the grant puts the granted bank last in search order.
  assign pick_start = (state == BURST) ? grant_inc : rr_ptr;

  rr_priority_pick #(
    .N  (NUM_BANK),
    .IW (ID_W)
  ) u_pick (
    .req   (~fifo_empty),
    .start (pick_start),
    .found (pick_found),
    .idx   (pick_idx)
  );

  always_comb begin
    state_n = state;
    grant_n = grant;
    rr_n    = rr_ptr;
    beat_n  = beat_cnt;
    pop_en  = 1'b0;
    pop_idx = '0;
    if (load_ok) begin
      case (state)
        IDLE: begin
          if (pick_found) begin
            pop_en  = 1'b1;
            pop_idx = pick_idx;
            grant_n = pick_idx;
            beat_n  = CNT_W'(1);
            state_n = BURST;
          end
        end
        BURST: begin
          if (!fifo_empty[grant] && (beat_cnt < CNT_W'(MAX_BURST))) begin
            pop_en  = 1'b1;
            pop_idx = grant;
            beat_n  = beat_cnt + 1'b1;
          end else if (pick_found) begin
            pop_en  = 1'b1;
            pop_idx = pick_idx;
            grant_n = pick_idx;
            beat_n  = CNT_W'(1);
            rr_n    = grant_inc;
          end else begin
            rr_n    = grant_inc;
            state_n = IDLE;
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end

  always_comb begin
    fifo_ren = '0;
    if (pop_en && !rst) fifo_ren[pop_idx] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      grant    <= '0;
      rr_ptr   <= '0;
      beat_cnt <= '0;
    end else begin
      state    <= state_n;
      grant    <= grant_n;
      rr_ptr   <= rr_n;
      beat_cnt <= beat_n;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid   <= 1'b0;
      out_data    <= '0;
      out_bank_id <= '0;
    end else if (load_ok) begin
      out_valid <= pop_en;
      if (pop_en) begin
        out_data    <= fifo_data[int'(pop_idx)*DATA_W +: DATA_W];
        out_bank_id <= pop_idx;
      end
    end
  end

endmodule

// File: tb/tb_out_fifo_return_arbiter.sv
// Bench for out_fifo_return_arbiter: FIFO models feed the DUT, an output-register
// model is checked every cycle, and directed scenarios pin the arbitration order.
module tb_out_fifo_return_arbiter;

  localparam int NB = 4;
  localparam int W  = 65;
  localparam int IW = 2;

  logic            clk = 1'b0;
  logic            rst;
  logic [NB-1:0]   fifo_empty;
  logic [NB*W-1:0] fifo_data;
  logic [NB-1:0]   fifo_ren;
  logic            out_valid;
  logic [W-1:0]    out_data;
  logic [IW-1:0]   out_bank_id;
  logic            out_ready;

  out_fifo_return_arbiter #(.NUM_BANK(NB), .DATA_W(W), .MAX_BURST(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .fifo_empty  (fifo_empty),
    .fifo_data   (fifo_data),
    .fifo_ren    (fifo_ren),
    .out_valid   (out_valid),
    .out_data    (out_data),
    .out_bank_id (out_bank_id),
    .out_ready   (out_ready)
  );

  always #5 clk = ~clk;

  int vectors    = 0;
  int miscompares = 0;
  int cyc        = 0;

  // Fall-through FIFO models, 16 deep per bank.
  logic [W-1:0] mem [NB][16];
  logic [7:0]   wr_ptr [NB];
  logic [7:0]   rd_ptr [NB] = '{default: 8'd0};

  always @(posedge clk) begin
    cyc <= cyc + 1;
    for (int b = 0; b < NB; b++)
      if (fifo_ren[b]) rd_ptr[b] <= rd_ptr[b] + 8'd1;
  end

  always_comb begin
    fifo_empty = '0;
    fifo_data  = '0;
    for (int b = 0; b < NB; b++) begin
      fifo_empty[b]      = (wr_ptr[b] == rd_ptr[b]);
      fifo_data[b*W +: W] = mem[b][rd_ptr[b][3:0]];
    end
  end

  function automatic logic [W-1:0] word(int b, int i);
    return {1'b1, 32'(b), 32'(i) + 32'hC0DE_0000};
  endfunction

  task automatic push(int b, logic [W-1:0] d);
    mem[b][wr_ptr[b][3:0]] = d;
    wr_ptr[b] = wr_ptr[b] + 8'd1;
  endtask

  // Accepted-beat log and expected sequence.
  int           acc_id[$];
  logic [W-1:0] acc_data[$];
  int           acc_cyc[$];
  int           exp_ids[$];
  logic [W-1:0] exp_wds[$];

  // Output register model: one-cycle pop-to-valid, hold under stall, clear on reset.
  logic         model_ok = 1'b0;
  logic         exp_valid;
  logic [W-1:0] exp_data;
  int           exp_id;

  always @(negedge clk) begin
    logic bad;
    if (model_ok) begin
      vectors++;
      if (out_valid !== exp_valid || out_data !== exp_data || int'(out_bank_id) != exp_id) begin
        miscompares++;
        $display("FAIL outreg @%0d: valid=%b id=%0d data=%h required valid=%b id=%0d data=%h",
                 cyc, out_valid, out_bank_id, out_data, exp_valid, exp_id, exp_data);
      end
    end
    bad = ($countones(fifo_ren) > 1) || ((fifo_ren & fifo_empty) != '0) ||
          (rst && fifo_ren != '0) ||
          (model_ok && !rst && exp_valid && !out_ready && fifo_ren != '0);
    vectors++;
    if (bad) begin
      miscompares++;
      $display("FAIL pop_rules @%0d: ren=%b empty=%b rst=%b ready=%b required legal single pop",
               cyc, fifo_ren, fifo_empty, rst, out_ready);
    end
    if (!rst && out_valid && out_ready) begin
      acc_id.push_back(int'(out_bank_id));
      acc_data.push_back(out_data);
      acc_cyc.push_back(cyc);
    end
    if (rst) begin
      exp_valid = 1'b0;
      exp_data  = '0;
      exp_id    = 0;
      model_ok  = 1'b1;
    end else if (model_ok && (!exp_valid || out_ready)) begin
      exp_valid = (fifo_ren != '0);
      for (int b = 0; b < NB; b++)
        if (fifo_ren[b]) begin
          exp_data = fifo_data[b*W +: W];
          exp_id   = b;
        end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(string name, logic [W-1:0] act, logic [W-1:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %h required %h", name, act, req);
    end
  endtask

  task automatic clear_logs();
    acc_id.delete(); acc_data.delete(); acc_cyc.delete();
    exp_ids.delete(); exp_wds.delete();
  endtask

  task automatic begin_test();
    tick();
    rst = 1'b1;
    tick();
    clear_logs();
  endtask

  task automatic release_rst();
    tick();
    rst = 1'b0;
  endtask

  task automatic wait_beats(string name, int n, int budget);
    int k = 0;
    while (acc_id.size() < n && k < budget) begin
      tick();
      k++;
    end
    if (acc_id.size() < n) begin
      vectors++;
      miscompares++;
      $display("FAIL %s_timeout: got %0d beats required %0d", name, acc_id.size(), n);
    end
  endtask

  task automatic check_results(string name, bit consec);
    repeat (3) tick();
    chk({name, "_count"}, W'(acc_id.size()), W'(exp_ids.size()));
    for (int i = 0; i < exp_ids.size() && i < acc_id.size(); i++) begin
      chk($sformatf("%s_id%0d", name, i), W'(acc_id[i]), W'(exp_ids[i]));
      chk($sformatf("%s_data%0d", name, i), acc_data[i], exp_wds[i]);
      if (consec && i > 0)
        chk($sformatf("%s_gap%0d", name, i), W'(acc_cyc[i] - acc_cyc[i-1]), W'(1));
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n[NB];
    rst       = 1'b1;
    out_ready = 1'b1;
    for (int b = 0; b < NB; b++) wr_ptr[b] = 8'd0;

    // Reset with every FIFO non-empty; first pop must be bank 0.
    for (int b = 0; b < NB; b++) begin
      push(b, word(b, 0));
      push(b, word(b, 1));
    end
    tick(); tick();
    @(negedge clk);
    chk("rst_ren", W'(fifo_ren), W'(0));
    chk("rst_valid", W'(out_valid), W'(0));
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk("first_pop", W'(fifo_ren), W'(4'b0001));
    for (int b = 0; b < NB; b++)
      for (int i = 0; i < 2; i++) begin
        exp_ids.push_back(b);
        exp_wds.push_back(word(b, i));
      end
    wait_beats("reset", 8, 40);
    check_results("reset", 1'b1);

    // Burst cap on a lone bank: re-granted without a bubble.
    begin_test();
    for (int i = 0; i < 6; i++) begin
      push(1, word(1, 10 + i));
      exp_ids.push_back(1);
      exp_wds.push_back(word(1, 10 + i));
    end
    release_rst();
    wait_beats("burst", 6, 40);
    check_results("burst", 1'b1);

    // Rotation: 0x4,1x4,2x4,3x4 then one each.
    begin_test();
    for (int b = 0; b < NB; b++) begin
      n[b] = 0;
      for (int i = 0; i < 5; i++) push(b, word(b, 20 + i));
    end
    for (int b = 0; b < NB; b++)
      for (int i = 0; i < 4; i++) begin
        exp_ids.push_back(b);
        exp_wds.push_back(word(b, 20 + n[b]));
        n[b]++;
      end
    for (int b = 0; b < NB; b++) begin
      exp_ids.push_back(b);
      exp_wds.push_back(word(b, 20 + n[b]));
    end
    release_rst();
    wait_beats("rotate", 20, 80);
    check_results("rotate", 1'b1);

    // Backpressure: A held for 3 stalled cycles, then B directly after A.
    begin_test();
    out_ready = 1'b0;
    push(2, word(2, 40));
    push(2, word(2, 41));
    exp_ids.push_back(2); exp_wds.push_back(word(2, 40));
    exp_ids.push_back(2); exp_wds.push_back(word(2, 41));
    release_rst();
    for (int k = 0; k < 10 && !out_valid; k++) tick();
    chk("bp_valid_seen", W'(out_valid), W'(1));
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk($sformatf("bp_hold_data%0d", k), out_data, word(2, 40));
      chk($sformatf("bp_hold_ren%0d", k), W'(fifo_ren), W'(0));
      tick();
    end
    out_ready = 1'b1;
    wait_beats("bp", 2, 20);
    check_results("bp", 1'b1);

    // Early switch 0,0,3 then idle with the pointer back at bank 0.
    begin_test();
    push(0, word(0, 50)); push(0, word(0, 51)); push(3, word(3, 52));
    exp_ids.push_back(0); exp_wds.push_back(word(0, 50));
    exp_ids.push_back(0); exp_wds.push_back(word(0, 51));
    exp_ids.push_back(3); exp_wds.push_back(word(3, 52));
    release_rst();
    wait_beats("switch", 3, 20);
    check_results("switch", 1'b1);
    clear_logs();
    push(1, word(1, 53)); push(0, word(0, 54));
    exp_ids.push_back(0); exp_wds.push_back(word(0, 54));
    exp_ids.push_back(1); exp_wds.push_back(word(1, 53));
    wait_beats("rrptr", 2, 20);
    check_results("rrptr", 1'b1);

    // Reset during beat 2 of a bank-2 burst.
    begin_test();
    for (int i = 0; i < 4; i++) push(2, word(2, 60 + i));
    release_rst();
    tick(); tick();
    chk("mid_beat2", out_data, word(2, 61));
    rst = 1'b1;
    push(0, word(0, 70));
    @(negedge clk);
    chk("mid_ren", W'(fifo_ren), W'(0));
    tick();
    @(negedge clk);
    chk("mid_valid", W'(out_valid), W'(0));
    chk("mid_pre_count", W'(acc_id.size()), W'(1));
    if (acc_data.size() > 0) chk("mid_pre_data", acc_data[0], word(2, 60));
    clear_logs();
    exp_ids.push_back(0); exp_wds.push_back(word(0, 70));
    exp_ids.push_back(2); exp_wds.push_back(word(2, 62));
    exp_ids.push_back(2); exp_wds.push_back(word(2, 63));
    tick();
    rst = 1'b0;
    wait_beats("mid", 3, 20);
    check_results("mid", 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
